// File: rtl/led7seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : led7seg_scan_decoder
// Description : Snoops the multiplexed segment/anode lines of a 4-digit
//               common-anode 7-segment display and rebuilds the digit values.
//               All 11 lines are synchronised, the pair {an_in, seg_in} must
//               stay unchanged for STABLE_CYC cycles, and then a single
//               capture decodes the active-low segment pattern into the digit
//               slot selected by the one-hot-low anode vector.
// Ports       : clk          - system clock, rising edge
//               rst_n        - asynchronous reset, active-low
//               seg_in[6:0]  - segment lines, active-low, bit0 = a .. bit6 = g
//               an_in[3:0]   - anode enables, active-low, bit0 = digit 0
//               digits[15:0] - decoded values, digit i at [4i+3:4i]
//               digit_valid  - bit i set when digit i holds a decoded value
//               invalid_seg  - sticky per digit: last capture was unknown
//               frame_done   - 1-cycle pulse once all 4 digits were captured
//               timeout      - no capture for TIMEOUT_CYC cycles
// Revision    : 1.0 - initial release
// ============================================================================
module led7seg_scan_decoder #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  invalid_seg,
    output logic        frame_done,
    output logic        timeout
);

    localparam logic [1:0] c_ST_SETTLE  = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_HOLD    = 2'd2;

    localparam logic [7:0] c_STABLE_LAST = 8'(STABLE_CYC - 1);

    localparam int                c_TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX  = c_TMO_W'(TIMEOUT_CYC);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

    // Input path: {an, seg} packed as [10:7] = an, [6:0] = seg.
    logic [10:0] sync1_q, sync2_q, prev_q;

    logic [1:0]  state_q, state_d;
    logic [7:0]  stab_cnt_q, stab_cnt_d;

    logic [15:0] digits_q, digits_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  invalid_q, invalid_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_done_q, frame_done_d;
    logic        timeout_q, timeout_d;
    logic [c_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic        w_equal;
    logic [3:0]  w_an_low;
    logic        w_onehot;
    logic [3:0]  w_sel;
    logic        w_capture;
    logic [3:0]  w_dec_val;
    logic        w_dec_known;

    assign w_equal   = (sync2_q == prev_q);
    assign w_an_low  = ~prev_q[10:7];
    assign w_onehot  = (w_an_low != 4'd0) && ((w_an_low & (w_an_low - 4'd1)) == 4'd0);
    // prev_q is the value that was proven stable, so the capture decodes it
    // rather than the live synchroniser output.
    assign w_sel     = w_onehot ? w_an_low : 4'd0;
    assign w_capture = (state_q == c_ST_CAPTURE);

    // Segment pattern decode (active-low, g..a).
    always_comb begin
        w_dec_val   = 4'h0;
        w_dec_known = 1'b1;
        case (prev_q[6:0])
            7'h40: w_dec_val = 4'h0;
            7'h79: w_dec_val = 4'h1;
            7'h24: w_dec_val = 4'h2;
            7'h30: w_dec_val = 4'h3;
            7'h19: w_dec_val = 4'h4;
            7'h12: w_dec_val = 4'h5;
            7'h02: w_dec_val = 4'h6;
            7'h78: w_dec_val = 4'h7;
            7'h00: w_dec_val = 4'h8;
            7'h10: w_dec_val = 4'h9;
            7'h7F: w_dec_val = 4'hF;
            default: begin
                w_dec_val   = 4'h0;
                w_dec_known = 1'b0;
            end
        endcase
    end

    // Stability FSM: one capture per stable window.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        case (state_q)
            c_ST_SETTLE: begin
                if (!w_equal) begin
                    stab_cnt_d = 8'd0;
                end else if (stab_cnt_q == c_STABLE_LAST) begin
                    stab_cnt_d = 8'd0;
                    // Blanking or several anodes low settle into HOLD silently.
                    state_d    = w_onehot ? c_ST_CAPTURE : c_ST_HOLD;
                end else begin
                    stab_cnt_d = stab_cnt_q + 8'd1;
                end
            end
            c_ST_CAPTURE: begin
                // A change arriving during the capture cycle must not be lost,
                // since prev_q absorbs it on this very edge.
                state_d    = w_equal ? c_ST_HOLD : c_ST_SETTLE;
                stab_cnt_d = 8'd0;
            end
            c_ST_HOLD: begin
                if (!w_equal) begin
                    state_d    = c_ST_SETTLE;
                    stab_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = c_ST_SETTLE;
                stab_cnt_d = 8'd0;
            end
        endcase
    end

    // Capture, frame tracking and timeout.
    always_comb begin
        digits_d     = digits_q;
        valid_d      = valid_q;
        invalid_d    = invalid_q;
        seen_d       = seen_q;
        frame_done_d = 1'b0;
        timeout_d    = timeout_q;
        tmo_cnt_d    = tmo_cnt_q;

        if (seen_q == 4'hF) begin
            seen_d       = 4'h0;
            frame_done_d = 1'b1;
        end

        if (w_capture) begin
            seen_d    = seen_d | w_sel;
            tmo_cnt_d = '0;
            timeout_d = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (w_sel[i]) begin
                    if (w_dec_known) begin
                        digits_d[4*i +: 4] = w_dec_val;
                        valid_d[i]         = 1'b1;
                        invalid_d[i]       = 1'b0;
                    end else begin
                        invalid_d[i]       = 1'b1;
                    end
                end
            end
        end else if (tmo_cnt_q != c_TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_cnt_q == c_TMO_LAST) begin
                timeout_d = 1'b1;
                valid_d   = 4'h0;
                seen_d    = 4'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 11'h7FF;
            sync2_q      <= 11'h7FF;
            prev_q       <= 11'h7FF;
            state_q      <= c_ST_SETTLE;
            stab_cnt_q   <= 8'd0;
            digits_q     <= 16'h0000;
            valid_q      <= 4'h0;
            invalid_q    <= 4'h0;
            seen_q       <= 4'h0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            sync1_q      <= {an_in, seg_in};
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            state_q      <= state_d;
            stab_cnt_q   <= stab_cnt_d;
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            invalid_q    <= invalid_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign invalid_seg = invalid_q;
    assign frame_done  = frame_done_q;
    assign timeout     = timeout_q;

endmodule
`default_nettype wire
